instruction_decode: RTL and testbench

//  Decode stage directly downstream of instruction fetch in the 8-bit pipeline.

---
 rtl/instruction_decode.sv | 105 ++++++++++
 tb/tb_instruction_decode.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode.sv
// instruction_decode
//   Decode stage of the 8-bit pipeline. Holds the IF/ID register, decodes the
//   instruction, reads the 8x8 register file (with writeback bypass), resolves
//   JMP in decode and drives the registered ID/EX slot.
// Ports
//   clk, reset            clock; synchronous active-low reset
//   if_pc, if_instr       instruction presented by fetch
//   wb_en/wb_addr/wb_data register-file write port from writeback
//   pcsrc, PC2            jump redirect back to fetch (combinational)
//   ex_*                  ID/EX register contents
//   decode_cnt            count of valid instructions decoded (JMP included)
module instruction_decode #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        if_pc,
   input  logic [7:0]        if_instr,
   input  logic              wb_en,
   input  logic [2:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              pcsrc,
   output logic [7:0]        PC2,
   output logic              ex_valid,
   output logic [1:0]        ex_op,
   output logic [2:0]        ex_rd,
   output logic [2:0]        ex_rs2,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [7:0]        ex_pc,
   output logic [CNT_W-1:0]  decode_cnt
);
   localparam logic [1:0] OP_ADDI = 2'b10;
   localparam logic [1:0] OP_JMP  = 2'b11;

   logic              r_id_valid;
   logic [7:0]        r_id_pc;
   logic [7:0]        r_id_instr;
   logic [DATA_W-1:0] r_rf [8];

   logic [1:0]        w_op;
   logic [2:0]        w_rd;
   logic [2:0]        w_rs2;
   logic              w_jmp;
   logic [DATA_W-1:0] w_rd_val;
   logic [DATA_W-1:0] w_rs2_val;
   logic [DATA_W-1:0] w_imm;

   assign w_op  = r_id_instr[7:6];
   assign w_rd  = r_id_instr[5:3];
   assign w_rs2 = r_id_instr[2:0];
   assign w_jmp = r_id_valid && (w_op == OP_JMP);
   assign w_imm = {{(DATA_W-3){r_id_instr[2]}}, r_id_instr[2:0]};

   // Held low while in reset so fetch never redirects on stale IF/ID contents.
   assign pcsrc = reset & w_jmp;
   assign PC2   = r_id_pc + {{2{r_id_instr[5]}}, r_id_instr[5:0]};

   // R0 is hardwired zero; a same-cycle writeback to the read address wins.
   always_comb begin
      w_rd_val = '0;
      if (w_rd != 3'd0)
         w_rd_val = (wb_en && wb_addr == w_rd) ? wb_data : r_rf[w_rd];
   end

   always_comb begin
      w_rs2_val = '0;
      if (w_rs2 != 3'd0)
         w_rs2_val = (wb_en && wb_addr == w_rs2) ? wb_data : r_rf[w_rs2];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_id_valid <= 1'b0;
         r_id_pc    <= '0;
         r_id_instr <= '0;
         ex_valid   <= 1'b0;
         ex_op      <= '0;
         ex_rd      <= '0;
         ex_rs2     <= '0;
         ex_a       <= '0;
         ex_b       <= '0;
         ex_pc      <= '0;
         decode_cnt <= '0;
         for (int i = 0; i < 8; i++) r_rf[i] <= '0;
      end else begin
         // Instruction fetched behind a taken jump is wrong-path: squash it.
         r_id_valid <= ~w_jmp;
         r_id_pc    <= if_pc;
         r_id_instr <= if_instr;

         ex_valid   <= r_id_valid && (w_op != OP_JMP);
         ex_op      <= w_op;
         ex_rd      <= w_rd;
         ex_rs2     <= (w_op == OP_ADDI) ? 3'd0 : w_rs2;
         ex_a       <= w_rd_val;
         ex_b       <= (w_op == OP_ADDI) ? w_imm : w_rs2_val;
         ex_pc      <= r_id_pc;
         decode_cnt <= decode_cnt + CNT_W'(r_id_valid);

         if (wb_en && wb_addr != 3'd0) r_rf[wb_addr] <= wb_data;
      end
   end
endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode
//   Randomized plus directed stimulus for instruction_decode. A reference model
//   of the stage (arrays and integer arithmetic) predicts each ID/EX update and
//   pushes it into a queue; a monitor pops one entry per edge and compares.
module tb_instruction_decode;
   logic       clk;
   logic       reset;
   logic [7:0] if_pc, if_instr;
   logic       wb_en;
   logic [2:0] wb_addr;
   logic [7:0] wb_data;
   logic       pcsrc;
   logic [7:0] PC2;
   logic       ex_valid;
   logic [1:0] ex_op;
   logic [2:0] ex_rd, ex_rs2;
   logic [7:0] ex_a, ex_b, ex_pc;
   logic [15:0] decode_cnt;

   instruction_decode #(.DATA_W(8), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .if_pc(if_pc), .if_instr(if_instr),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .pcsrc(pcsrc), .PC2(PC2), .ex_valid(ex_valid), .ex_op(ex_op),
      .ex_rd(ex_rd), .ex_rs2(ex_rs2), .ex_a(ex_a), .ex_b(ex_b),
      .ex_pc(ex_pc), .decode_cnt(decode_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        z;    // reset edge: every ex_* field must be zero
      logic        v;
      logic [1:0]  op;
      logic [2:0]  rd;
      logic [2:0]  rs2;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [7:0]  pc;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   // reference model state
   logic        m_idv;
   logic [7:0]  m_pc, m_ins;
   logic [7:0]  m_rf [8];
   logic [15:0] m_cnt;
   logic        last_jmp;
   logic [7:0]  last_tgt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] rdreg(input logic [2:0] a, input logic we,
                                        input logic [2:0] wa, input logic [7:0] wd);
      if (a == 0) return 8'h00;
      if (we && wa == a) return wd;
      return m_rf[a];
   endfunction

   task automatic step(input logic rs, input logic [7:0] pc, input logic [7:0] ins,
                       input logic we, input logic [2:0] wa, input logic [7:0] wd);
      exp_t e;
      int   op, off, imm;
      logic jmp;
      logic [7:0] tgt;
      @(negedge clk);
      reset = rs; if_pc = pc; if_instr = ins;
      wb_en = we; wb_addr = wa; wb_data = wd;
      e = '0; jmp = 1'b0; tgt = 8'h00;
      if (!rs) begin
         e.z = 1'b1;
         m_idv = 1'b0; m_pc = 8'h00; m_ins = 8'h00; m_cnt = 16'h0;
         for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
      end else begin
         op  = int'(m_ins[7:6]);
         jmp = m_idv && (op == 3);
         off = m_ins[5] ? int'(m_ins[5:0]) - 64 : int'(m_ins[5:0]);
         tgt = 8'((int'(m_pc) + off) & 255);
         imm = m_ins[2] ? int'(m_ins[2:0]) - 8 : int'(m_ins[2:0]);
         e.v   = m_idv && (op != 3);
         e.op  = m_ins[7:6];
         e.rd  = m_ins[5:3];
         e.rs2 = (op == 2) ? 3'd0 : m_ins[2:0];
         e.a   = rdreg(m_ins[5:3], we, wa, wd);
         e.b   = (op == 2) ? 8'(imm & 255) : rdreg(m_ins[2:0], we, wa, wd);
         e.pc  = m_pc;
         e.cnt = m_cnt + (m_idv ? 16'd1 : 16'd0);
         m_cnt = e.cnt;
         if (we && wa != 0) m_rf[wa] = wd;
         m_idv = !jmp; m_pc = pc; m_ins = ins;
      end
      q.push_back(e);
      #1;
      chk("pcsrc", 32'(pcsrc), 32'(jmp));
      if (jmp) chk("PC2", 32'(PC2), 32'(tgt));
      last_jmp = jmp; last_tgt = tgt;
   endtask

   // monitor: one ID/EX update per edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("ex_valid", 32'(ex_valid), 32'(e.v));
            chk("decode_cnt", 32'(decode_cnt), 32'(e.cnt));
            if (e.z) begin
               chk("rst ex_fields", {ex_op, ex_rd, ex_rs2, ex_a, ex_b, ex_pc}, 32'h0);
            end else if (e.v) begin
               chk("ex_op", 32'(ex_op), 32'(e.op));
               chk("ex_rd", 32'(ex_rd), 32'(e.rd));
               chk("ex_rs2", 32'(ex_rs2), 32'(e.rs2));
               chk("ex_a", 32'(ex_a), 32'(e.a));
               chk("ex_b", 32'(ex_b), 32'(e.b));
               chk("ex_pc", 32'(ex_pc), 32'(e.pc));
            end
         end
      end
   end

   initial begin
      logic [7:0] pc;
      reset = 1'b0; if_pc = 8'h00; if_instr = 8'h00;
      wb_en = 1'b0; wb_addr = 3'd0; wb_data = 8'h00;
      m_idv = 1'b0; m_pc = 8'h00; m_ins = 8'h00; m_cnt = 16'h0;
      for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
      last_jmp = 1'b0; last_tgt = 8'h00;

      step(0, 8'h00, 8'h00, 0, 0, 8'h00);
      step(0, 8'h00, 8'h00, 0, 0, 8'h00);
      // ADDI r1,3 then ADDI r1,-1
      step(1, 8'h00, 8'h8B, 0, 0, 8'h00);
      step(1, 8'h01, 8'h8F, 0, 0, 8'h00);
      // ADD r1,r2 with writeback to R2 while it sits in IF/ID
      step(1, 8'h02, 8'h0A, 0, 0, 8'h00);
      step(1, 8'h03, 8'h50, 1, 3'd2, 8'h5A);
      step(1, 8'h04, 8'h0A, 0, 0, 8'h00);
      // JMP -2 at 0x05, then wrong-path instruction
      step(1, 8'h05, 8'hFE, 0, 0, 8'h00);
      step(1, 8'h06, 8'h12, 0, 0, 8'h00);
      step(1, 8'h03, 8'h00, 0, 0, 8'h00);
      // JMP +5 at 0xFD wraps to 0x02
      step(1, 8'hFD, 8'hC5, 0, 0, 8'h00);
      step(1, 8'hFE, 8'hC1, 0, 0, 8'h00);
      step(1, 8'h02, 8'h00, 0, 0, 8'h00);
      // write to R0 ignored, then ADD r0,r0
      step(1, 8'h03, 8'h00, 1, 3'd0, 8'hAA);
      step(1, 8'h04, 8'h00, 0, 0, 8'h00);
      // populate registers, then mid-stream reset with a jump in flight
      for (int i = 1; i < 8; i++) step(1, 8'(i), 8'h8B, 1, 3'(i), 8'(i * 17));
      step(1, 8'h10, 8'hC3, 1, 3'd4, 8'h77);
      step(0, 8'h11, 8'h00, 1, 3'd5, 8'h66);
      step(0, 8'h12, 8'h00, 0, 0, 8'h00);
      for (int i = 1; i < 8; i++) step(1, 8'(i), 8'(i * 9), 0, 0, 8'h00);
      step(1, 8'h08, 8'h00, 0, 0, 8'h00);

      // randomized stream; fetch follows the redirect
      pc = 8'h00;
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 39) != 0), pc, 8'($urandom),
              1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom));
         pc = last_jmp ? last_tgt : pc + 8'h01;
      end
      step(1, pc, 8'h00, 0, 0, 8'h00);

      repeat (3) @(negedge clk);
      chk("scoreboard drained", 32'(q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
